// File: rtl/alu_sched_pkg.sv
// ============================================================================
// Module : alu_sched_pkg
// Brief  : Shared FSM encoding, default widths and the round-robin index helper
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_OP_W   = 3;
   localparam int OP_COUNT_W = 16;

   // Requester index 'off' positions after 'last', wrapping modulo n.
   function automatic int rr_index(input int last, input int off, input int n);
      return (last + off) % n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rr_sched_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, searching upward from last_grant+1
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    last_grant_i,
   input  logic               enable_i,
   output logic [NUM_REQ-1:0] grant_oh_o,
   output logic [ID_W-1:0]    grant_idx_o,
   output logic               any_grant_o
);

   // Scan farthest-first so the nearest asserted requester overwrites the rest.
   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      any_grant_o = 1'b0;
      if (enable_i) begin
         for (int off = NUM_REQ; off >= 1; off--) begin
            if (req_i[rr_index(int'(last_grant_i), off, NUM_REQ)]) begin
               grant_oh_o = '0;
               grant_oh_o[rr_index(int'(last_grant_i), off, NUM_REQ)] = 1'b1;
               grant_idx_o = ID_W'(rr_index(int'(last_grant_i), off, NUM_REQ));
               any_grant_o = 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_rr_sched.sv
// ============================================================================
// Module : alu_rr_sched
// Brief  : Round-robin sharing of one external ALU between NUM_REQ requesters.
//          Define ALU_RR_SCHED_STATS_EN to build the completed-op counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rr_sched
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int OP_W    = DEF_OP_W,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0] req_op,
   output logic [DATA_W-1:0]       alu_a,
   output logic [DATA_W-1:0]       alu_b,
   output logic [OP_W-1:0]         alu_op,
   input  logic [2*DATA_W-1:0]     alu_res,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [2*DATA_W-1:0]     rsp_res,
   output logic [OP_COUNT_W-1:0]   op_count
);

   state_e              state_q;
   logic [ID_W-1:0]     last_grant_q;
   logic [ID_W-1:0]     id_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [OP_W-1:0]     op_q;
   logic [ID_W-1:0]     rsp_id_q;
   logic [2*DATA_W-1:0] rsp_res_q;
   logic                rsp_valid_q;

   logic [NUM_REQ-1:0]  grant_oh;
   logic [ID_W-1:0]     grant_idx;
   logic                any_grant;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .enable_i     (state_q == ST_IDLE),
      .grant_oh_o   (grant_oh),
      .grant_idx_o  (grant_idx),
      .any_grant_o  (any_grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         rsp_id_q     <= '0;
         rsp_res_q    <= '0;
         rsp_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_grant) begin
                  a_q          <= req_a[grant_idx*DATA_W +: DATA_W];
                  b_q          <= req_b[grant_idx*DATA_W +: DATA_W];
                  op_q         <= req_op[grant_idx*OP_W +: OP_W];
                  id_q         <= grant_idx;
                  last_grant_q <= grant_idx;
                  state_q      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_res_q   <= alu_res;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Operand registers only change on a grant, so the ALU inputs hold outside EXEC.
   assign req_ready = grant_oh;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_res   = rsp_res_q;

`ifdef ALU_RR_SCHED_STATS_EN
   logic [OP_COUNT_W-1:0] op_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q <= '0;
      end else if (state_q == ST_RESP && rsp_ready && op_count_q != '1) begin
         op_count_q <= op_count_q + 1'b1;
      end
   end

   assign op_count = op_count_q;
`else
   assign op_count = '0;
`endif

endmodule

`default_nettype wire
